// File: rtl/led_trail_fader.sv
// LED output stage: holds swept LEDs at full brightness, decays them geometrically per sweep step,
// and renders brightness with a free-running PWM. Define LED_TRAIL_GAMMA_EN for a squared (gamma ~2) duty curve.
module led_trail_fader #(
   parameter int unsigned NUM_LEDS    = 10,
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned DECAY_SHIFT = 1
) (
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   input  logic                step_clk,
   input  logic                fade_en,
   input  logic [NUM_LEDS-1:0] led_in,
   output logic [NUM_LEDS-1:0] LEDR
);

   localparam logic [PWM_BITS-1:0] MAX = '1;

   logic                step_q;
   logic                step_qq;
   logic                step_pulse;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] bright [NUM_LEDS];
   logic [PWM_BITS-1:0] duty_c [NUM_LEDS];
   logic [PWM_BITS-1:0] duty   [NUM_LEDS];
   logic [NUM_LEDS-1:0] full_c;
   logic [NUM_LEDS-1:0] full;

   // Both step registers reset low, so step_clk already high at release counts as an edge.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         step_q  <= 1'b0;
         step_qq <= 1'b0;
         pwm_cnt <= '0;
      end else begin
         step_q  <= step_clk;
         step_qq <= step_q;
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   assign step_pulse = step_q & ~step_qq;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int unsigned i = 0; i < NUM_LEDS; i++) bright[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            if (!fade_en)
               bright[i] <= led_in[i] ? MAX : '0;
            else if (led_in[i])
               bright[i] <= MAX;
            else if (step_pulse)
               bright[i] <= bright[i] >> DECAY_SHIFT;
         end
      end
   end

`ifdef LED_TRAIL_GAMMA_EN
   logic [2*PWM_BITS-1:0] prod;

   always_comb begin
      prod   = '0;
      full_c = '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
         prod      = {{PWM_BITS{1'b0}}, bright[i]} * {{PWM_BITS{1'b0}}, bright[i]};
         duty_c[i] = PWM_BITS'(prod >> PWM_BITS);
         full_c[i] = (bright[i] == MAX);
      end
   end

   // The solid-on flag is pipelined alongside duty so both reach LEDR in the same cycle.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         full <= '0;
         for (int unsigned i = 0; i < NUM_LEDS; i++) duty[i] <= '0;
      end else begin
         full <= full_c;
         for (int unsigned i = 0; i < NUM_LEDS; i++) duty[i] <= duty_c[i];
      end
   end
`else
   always_comb begin
      full_c = '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
         duty_c[i] = bright[i];
         full_c[i] = (bright[i] == MAX);
      end
   end

   always_comb begin
      full = full_c;
      for (int unsigned i = 0; i < NUM_LEDS; i++) duty[i] = duty_c[i];
   end
`endif

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         LEDR <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_LEDS; i++)
            LEDR[i] <= full[i] | (pwm_cnt < duty[i]);
      end
   end

endmodule

// File: tb/tb_led_trail_fader.sv
// Self-checking bench for led_trail_fader: table-driven decay vectors plus hand sequences
// for latency, simultaneous step/light, pass-through, PWM duty counts and reset behaviour.
module tb_led_trail_fader;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N;
   logic       step_clk;
   logic       fade_en;
   logic [9:0] led_in;
   logic [9:0] LEDR;

`ifdef LED_TRAIL_GAMMA_EN
   localparam int LAT     = 3;
   localparam int DUTY127 = 63;
   localparam int DUTY63  = 15;
`else
   localparam int LAT     = 2;
   localparam int DUTY127 = 127;
   localparam int DUTY63  = 63;
`endif

   led_trail_fader #(.NUM_LEDS(10), .PWM_BITS(8), .DECAY_SHIFT(1)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .step_clk (step_clk),
      .fade_en  (fade_en),
      .led_in   (led_in),
      .LEDR     (LEDR)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [9:0] led;
      logic       fade;
      logic       stp;
      int         b0;
      int         b1;
   } vec_t;

   vec_t vecs[16];
   int   errors = 0;
   int   checks = 0;
   int   exp_q[$];

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic push_exp(input int v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string name, input int actual);
      int e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: actual=%0d, no expected value queued", name, actual);
      end else begin
         e = exp_q.pop_front();
         if (actual != e) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, actual, e);
         end
      end
   endtask

   // One full step_clk period: the pulse lands during the high half.
   task automatic do_step();
      step_clk = 1'b1;
      tick(3);
      step_clk = 1'b0;
      tick(3);
   endtask

   task automatic count_high(input int ch, output int n);
      n = 0;
      repeat (256) begin
         tick(1);
         n += int'(LEDR[ch]);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int n;

      vecs[0]  = '{10'h001, 1'b0, 1'b0, 255, 0};
      vecs[1]  = '{10'h001, 1'b1, 1'b0, 255, 0};
      vecs[2]  = '{10'h002, 1'b1, 1'b0, 255, 255};
      vecs[3]  = '{10'h002, 1'b1, 1'b1, 127, 255};
      vecs[4]  = '{10'h002, 1'b1, 1'b1, 63, 255};
      vecs[5]  = '{10'h002, 1'b1, 1'b1, 31, 255};
      vecs[6]  = '{10'h002, 1'b1, 1'b1, 15, 255};
      vecs[7]  = '{10'h002, 1'b1, 1'b1, 7, 255};
      vecs[8]  = '{10'h002, 1'b1, 1'b1, 3, 255};
      vecs[9]  = '{10'h002, 1'b1, 1'b1, 1, 255};
      vecs[10] = '{10'h002, 1'b1, 1'b1, 0, 255};
      vecs[11] = '{10'h002, 1'b1, 1'b1, 0, 255};
      vecs[12] = '{10'h001, 1'b1, 1'b1, 255, 127};
      vecs[13] = '{10'h001, 1'b1, 1'b1, 255, 63};
      vecs[14] = '{10'h001, 1'b0, 1'b0, 255, 0};
      vecs[15] = '{10'h000, 1'b1, 1'b1, 127, 0};

      // Reset held with all LEDs requested
      RESET_N  = 1'b0;
      step_clk = 1'b0;
      fade_en  = 1'b1;
      led_in   = 10'h3FF;
      tick(5);
      push_exp(0); check("reset_ledr", int'(LEDR));
      push_exp(0); check("reset_bright0", int'(dut.bright[0]));
      push_exp(0); check("reset_bright9", int'(dut.bright[9]));
      RESET_N = 1'b1;
      tick(LAT - 1);
      push_exp(0); check("release_ledr_early", int'(LEDR));
      tick(1);
      push_exp(10'h3FF); check("release_ledr_on", int'(LEDR));

      // Tail decay, pass-through and resume vectors
      foreach (vecs[i]) begin
         led_in  = vecs[i].led;
         fade_en = vecs[i].fade;
         push_exp(vecs[i].b0);
         push_exp(vecs[i].b1);
         if (vecs[i].stp) do_step();
         else tick(3);
         check($sformatf("vec%0d_bright0", i), int'(dut.bright[0]));
         check($sformatf("vec%0d_bright1", i), int'(dut.bright[1]));
      end

      // fade_en 1->0 clears tails on the very next cycle
      led_in = 10'h002;
      tick(3);
      led_in = 10'h000;
      do_step();
      push_exp(63); check("pre_clear_bright0", int'(dut.bright[0]));
      fade_en = 1'b0;
      tick(1);
      push_exp(0); check("clear_bright0", int'(dut.bright[0]));
      push_exp(0); check("clear_bright1", int'(dut.bright[1]));
      tick(LAT);
      push_exp(0); check("clear_ledr", int'(LEDR));
      fade_en = 1'b1;

      // led_in rising in the same cycle as step_pulse wins over decay
      led_in = 10'h004;
      tick(2);
      led_in   = 10'h000;
      step_clk = 1'b1;
      tick(1);
      led_in = 10'h008;
      tick(1);
      push_exp(255); check("simul_bright3", int'(dut.bright[3]));
      push_exp(127); check("simul_bright2", int'(dut.bright[2]));
      step_clk = 1'b0;
      tick(3);

      // PWM duty counts over one period
      led_in = 10'h001;
      tick(3);
      led_in = 10'h000;
      do_step();
      do_step();
      push_exp(63); check("pwm_bright0_63", int'(dut.bright[0]));
      push_exp(DUTY63);
      count_high(0, n);
      check("pwm_high_63", n);
      led_in = 10'h001;
      tick(3);
      led_in = 10'h000;
      do_step();
      push_exp(DUTY127);
      count_high(0, n);
      check("pwm_high_127", n);
      led_in = 10'h001;
      tick(LAT + 1);
      push_exp(256);
      count_high(0, n);
      check("pwm_high_255", n);
      led_in  = 10'h000;
      fade_en = 1'b0;
      tick(LAT + 1);
      push_exp(0);
      count_high(0, n);
      check("pwm_high_0", n);
      fade_en = 1'b1;

      // led_in -> LEDR latency on an idle channel
      led_in = 10'h020;
      tick(LAT - 1);
      push_exp(0); check("latency_early", int'(LEDR[5]));
      tick(1);
      push_exp(1); check("latency_on", int'(LEDR[5]));

      // Asynchronous reset mid-trail clears immediately, no tail afterwards
      led_in = 10'h0C0;
      tick(3);
      led_in = 10'h000;
      do_step();
      push_exp(127); check("premid_bright6", int'(dut.bright[6]));
      @(posedge CLOCK_50);
      #3;
      RESET_N = 1'b0;
      #1;
      push_exp(0); check("midreset_ledr", int'(LEDR));
      push_exp(0); check("midreset_bright6", int'(dut.bright[6]));
      tick(2);
      RESET_N = 1'b1;
      push_exp(0);
      count_high(6, n);
      check("post_reset_high", n);

      // step_clk already high at reset release counts as a rising edge
      RESET_N  = 1'b0;
      step_clk = 1'b1;
      led_in   = 10'h001;
      tick(2);
      RESET_N = 1'b1;
      tick(1);
      led_in = 10'h000;
      tick(2);
      push_exp(127); check("first_sample_edge", int'(dut.bright[0]));
      step_clk = 1'b0;
      tick(2);

      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard_drain: actual=%0d leftover expected=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
